// File: rtl/instr_fetch.sv
// Fetch stage: owns the PC, runs the imem req/valid handshake, holds the instruction and decodes its fields.
// Latency: memory latency + 1 cycle to ISSUE. Backpressure: stall freezes ISSUE. A HALT opcode stops fetch until rst.
module instr_fetch #(
  parameter int unsigned       ADDR_W   = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [15:0]       imem_rdata,
  input  logic              imem_valid,
  input  logic              stall,
  input  logic              jump_en,
  input  logic [ADDR_W-1:0] jump_addr,
  output logic [3:0]        op_code,
  output logic [3:0]        rd,
  output logic [3:0]        rs,
  output logic [3:0]        rt,
  output logic              instr_valid,
  output logic [ADDR_W-1:0] pc,
  output logic              halted
);

  localparam logic [3:0] OP_HALT = 4'b1111;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_ISSUE = 2'd1,
    S_HALT  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [15:0]       ir_q, ir_d;
  logic              req_q, req_d;
  logic              vld_q, vld_d;
  logic              halted_q, halted_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_FETCH;
      pc_q     <= RESET_PC;
      ir_q     <= 16'h0000;
      req_q    <= 1'b0;
      vld_q    <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      req_q    <= req_d;
      vld_q    <= vld_d;
      halted_q <= halted_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    req_d    = req_q;
    vld_d    = vld_q;
    halted_d = halted_q;

    case (state_q)
      S_FETCH: begin
        // The first cycle out of reset sits in FETCH with no request raised yet;
        // a response is only meaningful once the request is actually on the bus.
        req_d = 1'b1;
        if (req_q && imem_valid) begin
          req_d = 1'b0;
          if (imem_rdata[15:12] == OP_HALT) begin
            state_d  = S_HALT;
            halted_d = 1'b1;
          end else begin
            state_d = S_ISSUE;
            ir_d    = imem_rdata;
            vld_d   = 1'b1;
          end
        end
      end
      S_ISSUE: begin
        if (!stall) begin
          pc_d    = jump_en ? jump_addr : pc_q + 1'b1;
          ir_d    = 16'h0000;
          vld_d   = 1'b0;
          req_d   = 1'b1;
          state_d = S_FETCH;
        end
      end
      default: ;
    endcase
  end

  assign imem_req    = req_q;
  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign op_code     = ir_q[15:12];
  assign rd          = ir_q[11:8];
  assign rs          = ir_q[7:4];
  assign rt          = ir_q[3:0];
  assign instr_valid = vld_q;
  assign halted      = halted_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: inputs driven and outputs sampled on the falling edge.
module tb_instr_fetch;

  logic       clk;
  logic       rst;
  logic       imem_req;
  logic [7:0] imem_addr;
  logic [15:0] imem_rdata;
  logic       imem_valid;
  logic       stall;
  logic       jump_en;
  logic [7:0] jump_addr;
  logic [3:0] op_code, rd, rs, rt;
  logic       instr_valid;
  logic [7:0] pc;
  logic       halted;

  int errors = 0;
  int checks = 0;

  logic [34:0] obs;
  logic [34:0] expv;

  instr_fetch #(.ADDR_W(8), .RESET_PC(8'h00)) dut (
    .clk        (clk),
    .rst        (rst),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .imem_valid (imem_valid),
    .stall      (stall),
    .jump_en    (jump_en),
    .jump_addr  (jump_addr),
    .op_code    (op_code),
    .rd         (rd),
    .rs         (rs),
    .rt         (rt),
    .instr_valid(instr_valid),
    .pc         (pc),
    .halted     (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign obs = {imem_req, imem_addr, pc, instr_valid, halted, op_code, rd, rs, rt};

  // Packs the expected output vector {req, addr, pc, instr_valid, halted, fields}.
  function automatic logic [34:0] ev(input logic req, input logic [7:0] addr, input logic [7:0] p,
                                     input logic v, input logic h, input logic [15:0] ir);
    return {req, addr, p, v, h, ir};
  endfunction

  task automatic idle_inputs();
    imem_valid = 1'b0;
    imem_rdata = 16'h0000;
    stall      = 1'b0;
    jump_en    = 1'b0;
    jump_addr  = 8'h00;
  endtask

  // Leaves the bench at the first cycle after release: FETCH, request up, pc=0.
  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      expv = ev(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 16'h0000);
      checks++;
      if (obs !== expv) begin
        errors++;
        $display("FAIL reset_hold[%0d]: got %h expected %h", i, obs, expv);
      end
    end
    rst = 1'b0;
    @(negedge clk);
    expv = ev(1'b1, 8'h00, 8'h00, 1'b0, 1'b0, 16'h0000);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL reset_first_req: got %h expected %h", obs, expv);
    end
  endtask

  task automatic test_sequential();
    do_reset();
    imem_valid = 1'b1;
    imem_rdata = 16'h8123;
    @(negedge clk);
    expv = ev(1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 16'h8123);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL seq_first_issue: got %h expected %h", obs, expv);
    end
    imem_valid = 1'b0;
    @(negedge clk);
    expv = ev(1'b1, 8'h01, 8'h01, 1'b0, 1'b0, 16'h0000);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL seq_second_fetch: got %h expected %h", obs, expv);
    end
    imem_valid = 1'b1;
    imem_rdata = 16'h4567;
    @(negedge clk);
    expv = ev(1'b0, 8'h01, 8'h01, 1'b1, 1'b0, 16'h4567);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL seq_second_issue: got %h expected %h", obs, expv);
    end
    imem_valid = 1'b0;
    @(negedge clk);
    expv = ev(1'b1, 8'h02, 8'h02, 1'b0, 1'b0, 16'h0000);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL seq_third_fetch: got %h expected %h", obs, expv);
    end
  endtask

  task automatic test_latency_stall();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      expv = ev(1'b1, 8'h00, 8'h00, 1'b0, 1'b0, 16'h0000);
      checks++;
      if (obs !== expv) begin
        errors++;
        $display("FAIL lat_req_held[%0d]: got %h expected %h", i, obs, expv);
      end
      if (i == 3) begin
        imem_valid = 1'b1;
        imem_rdata = 16'h9ABC;
      end
      @(negedge clk);
    end
    expv = ev(1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 16'h9ABC);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL lat_issue: got %h expected %h", obs, expv);
    end
    // A stray response during ISSUE must be ignored, even with a HALT opcode.
    imem_rdata = 16'hF123;
    stall      = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      expv = ev(1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 16'h9ABC);
      checks++;
      if (obs !== expv) begin
        errors++;
        $display("FAIL stall_hold[%0d]: got %h expected %h", i, obs, expv);
      end
    end
    stall      = 1'b0;
    imem_valid = 1'b0;
    @(negedge clk);
    expv = ev(1'b1, 8'h01, 8'h01, 1'b0, 1'b0, 16'h0000);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL stall_release: got %h expected %h", obs, expv);
    end
  endtask

  task automatic test_jump_wrap();
    do_reset();
    imem_valid = 1'b1;
    imem_rdata = 16'h1000;
    @(negedge clk);
    imem_valid = 1'b0;
    jump_en    = 1'b1;
    jump_addr  = 8'hFF;
    @(negedge clk);
    expv = ev(1'b1, 8'hFF, 8'hFF, 1'b0, 1'b0, 16'h0000);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL jump_target: got %h expected %h", obs, expv);
    end
    jump_en    = 1'b0;
    imem_valid = 1'b1;
    imem_rdata = 16'h2345;
    @(negedge clk);
    expv = ev(1'b0, 8'hFF, 8'hFF, 1'b1, 1'b0, 16'h2345);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL jump_issue: got %h expected %h", obs, expv);
    end
    imem_valid = 1'b0;
    @(negedge clk);
    expv = ev(1'b1, 8'h00, 8'h00, 1'b0, 1'b0, 16'h0000);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL pc_wrap: got %h expected %h", obs, expv);
    end
    imem_valid = 1'b1;
    imem_rdata = 16'h3111;
    @(negedge clk);
    imem_valid = 1'b0;
    stall      = 1'b1;
    jump_en    = 1'b1;
    jump_addr  = 8'h40;
    @(negedge clk);
    expv = ev(1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 16'h3111);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL stall_jump_hold: got %h expected %h", obs, expv);
    end
    stall   = 1'b0;
    jump_en = 1'b0;
    @(negedge clk);
    expv = ev(1'b1, 8'h01, 8'h01, 1'b0, 1'b0, 16'h0000);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL stall_jump_no_redirect: got %h expected %h", obs, expv);
    end
  endtask

  task automatic test_halt();
    do_reset();
    imem_valid = 1'b1;
    imem_rdata = 16'h1000;
    @(negedge clk);
    imem_valid = 1'b0;
    jump_en    = 1'b1;
    jump_addr  = 8'h05;
    @(negedge clk);
    expv = ev(1'b1, 8'h05, 8'h05, 1'b0, 1'b0, 16'h0000);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL halt_setup: got %h expected %h", obs, expv);
    end
    jump_en    = 1'b0;
    imem_valid = 1'b1;
    imem_rdata = 16'hF000;
    @(negedge clk);
    expv = ev(1'b0, 8'h05, 8'h05, 1'b0, 1'b1, 16'h0000);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL halt_enter: got %h expected %h", obs, expv);
    end
    for (int i = 0; i < 20; i++) begin
      imem_valid = i[0];
      imem_rdata = 16'h8123;
      stall      = i[1];
      jump_en    = 1'b1;
      jump_addr  = 8'h33;
      @(negedge clk);
      expv = ev(1'b0, 8'h05, 8'h05, 1'b0, 1'b1, 16'h0000);
      checks++;
      if (obs !== expv) begin
        errors++;
        $display("FAIL halt_hold[%0d]: got %h expected %h", i, obs, expv);
      end
    end
    rst = 1'b1;
    idle_inputs();
    @(negedge clk);
    expv = ev(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 16'h0000);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL halt_reset: got %h expected %h", obs, expv);
    end
    rst = 1'b0;
    @(negedge clk);
    expv = ev(1'b1, 8'h00, 8'h00, 1'b0, 1'b0, 16'h0000);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL halt_restart: got %h expected %h", obs, expv);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    imem_valid = 1'b1;
    imem_rdata = 16'h1000;
    @(negedge clk);
    imem_valid = 1'b0;
    @(negedge clk);
    expv = ev(1'b1, 8'h01, 8'h01, 1'b0, 1'b0, 16'h0000);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL mid_setup: got %h expected %h", obs, expv);
    end
    rst        = 1'b1;
    imem_valid = 1'b1;
    imem_rdata = 16'h8123;
    @(negedge clk);
    expv = ev(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 16'h0000);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL mid_reset: got %h expected %h", obs, expv);
    end
    rst        = 1'b0;
    imem_valid = 1'b0;
    @(negedge clk);
    expv = ev(1'b1, 8'h00, 8'h00, 1'b0, 1'b0, 16'h0000);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL mid_restart: got %h expected %h", obs, expv);
    end
    imem_valid = 1'b1;
    imem_rdata = 16'h4567;
    @(negedge clk);
    imem_valid = 1'b0;
    expv = ev(1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 16'h4567);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL mid_refetch: got %h expected %h", obs, expv);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_sequential();
    test_latency_stall();
    test_jump_wrap();
    test_halt();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage: owns the program counter, issues reads to instruction memory through a req/valid handshake, and holds the fetched instruction in an instruction register. It presents the decoded fields, including the 4-bit `op_code`, to the `controller` and the datapath. It sits directly upstream of `controller`. It supports downstream stall, jump redirect and a halt opcode.

## Interface
- `ADDR_W`, 8, instruction address width; the PC wraps modulo 2^ADDR_W
- `RESET_PC`, 0, PC value loaded on reset
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  synchronous, active-high reset
- `imem_req`  out  1  read request to instruction memory
- `imem_addr`  out  ADDR_W  read address; equals `pc` while `imem_req`=1
- `imem_rdata`  in  16  instruction word; meaningful only when `imem_valid`=1
- `imem_valid`  in  1  read data return
- `stall`  in  1  downstream cannot accept the issued instruction
- `jump_en`  in  1  redirect the PC; honoured only on a consume cycle
- `jump_addr`  in  ADDR_W  jump target
- `op_code`  out  4  instruction bits [15:12]
- `rd`, `rs`, `rt`  out  4 each  instruction bits [11:8], [7:4], [3:0]
- `instr_valid`  out  1  fields hold a valid instruction
- `pc`  out  ADDR_W  address of the current or pending instruction
- `halted`  out  1  fetch has stopped on a HALT opcode (4'b1111)

## Operation
- States:
  - FETCH: `imem_req`=1.
  - ISSUE: `instr_valid`=1.
  - HALT: no requests are issued.
- Reset values:
  - State is FETCH, `pc`=RESET_PC, IR=16'h0000.
  - `op_code`, `rd`, `rs`, `rt` are 0, `instr_valid`=0, `halted`=0, `imem_req`=0.
  - `imem_req` first rises in the cycle after reset deasserts.
  - `op_code`=0 decodes to no write enables in `controller`.
- FETCH:
  - `imem_req`=1 and `imem_addr`=`pc`, both held until `imem_valid`=1.
  - On `imem_valid`=1 with `imem_rdata[15:12]`≠4'b1111: latch the word into IR and go to ISSUE.
  - On `imem_valid`=1 with `imem_rdata[15:12]`=4'b1111: IR is not loaded, go to HALT.
- ISSUE:
  - The outputs `op_code`, `rd`, `rs`, `rt` come from IR, and `instr_valid`=1.
  - With `stall`=1, all outputs hold.
  - A consume cycle is any ISSUE cycle with `stall`=0. On it, `pc` loads `jump_addr` if `jump_en`=1, otherwise `pc`+1 (truncated to ADDR_W bits, so max wraps to 0). The block then returns to FETCH.
  - On leaving ISSUE, IR clears to 0, so `op_code`=0 and `instr_valid`=0.
- HALT:
  - `halted`=1, `imem_req`=0, all fields are 0, `pc` holds the HALT instruction's address.
  - The only exit is `rst`.
- Ignored inputs:
  - `imem_valid` outside FETCH.
  - `jump_en` outside a consume cycle.
  - `stall` outside ISSUE.
- `rst` has priority over every event. Reset in any state, including mid-FETCH with a request outstanding, returns to the reset values above. Instruction memory shares `rst` and must drop any outstanding request on it.

## Timing
- All outputs are registered, except `imem_addr`, which is a direct copy of `pc`.
- Memory latency k ≥ 0 cycles after `imem_req` rises; zero latency means `imem_valid`=1 in the same cycle as the request.
- `instr_valid` rises on the edge that samples `imem_valid`=1.
- With k=0 and no stall, throughput is one instruction every 2 cycles: FETCH, ISSUE, FETCH, ...
- A jump takes effect on the next FETCH. `imem_addr`=`jump_addr` in the cycle after the consume cycle.
- `stall` and `jump_en` in the same cycle: the stall wins and the jump is ignored. Downstream must reassert `jump_en` on the eventual consume cycle.

## Test plan
- Reset and first fetch:
  - Stimulus: `rst` high for 2 cycles, then low.
  - Required: during reset all outputs are 0 and `pc`=0. Cycle 1 after release: `imem_req`=1, `imem_addr`=0.
- Sequential fetch:
  - Stimulus: memory with k=0 returning 16'h8123 then 16'h4567.
  - Required: `op_code`=8, `rd`=1, `rs`=2, `rt`=3 with `instr_valid` at cycle 2. Then `op_code`=4 at cycle 4 with `pc`=1.
- Variable latency and stall:
  - Stimulus: k=3, then `stall`=1 for 4 cycles during ISSUE.
  - Required: `imem_req` and `imem_addr` stable for 4 cycles. Fields and `instr_valid` hold through the stall. `pc` increments only after `stall` falls.
- Jump and wrap:
  - Stimulus: part 1, `jump_en`=1 with `jump_addr`=8'hFF on a consume cycle. Part 2, `stall`=1 and `jump_en`=1 together.
  - Required for part 1: next `imem_addr`=8'hFF, and after consuming that instruction `imem_addr`=0.
  - Required for part 2: no redirect.
- Halt:
  - Stimulus: fetch of 16'hF000 at `pc`=5.
  - Required: `halted`=1, `imem_req`=0, `instr_valid`=0 and `pc`=5 held for 20 cycles. Any `imem_valid` pulse is ignored.
- Reset mid-operation:
  - Stimulus: `rst` asserted in FETCH with `imem_valid` arriving in the same cycle.
  - Required: the instruction is not latched and the block returns to reset values with `pc`=RESET_PC.
